window_sequencer: RTL and testbench
===================================

WINDOW_SEQUENCER -- requirements
Module: window_sequencer

Interface
REQ-001 Parameters: RD_PER_WIN default 16 (4x4 source-window reads per window); WR_PER_WIN default 4 (2x2 result writes per window); CNT_W default 5 (width of the beat counters).
REQ-002 Ports (name direction width meaning):
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begins a frame.
- o_inc_raddr  out  1  one-cycle pulse to the address counter's read-increment input.
- i_r_ready  in  1  read address valid pulse from the address counter.
- o_inc_waddr  out  1  one-cycle pulse to the address counter's write-increment input.
- i_w_ready  in  1  write address valid pulse from the address counter.
- i_addr_done  in  1  pulse: the last frame write address has been issued.
- o_mem_read  out  1  memory read strobe.
- o_mem_write  out  1  memory write strobe.
- i_mem_ack  in  1  memory transfer complete.
- o_load_en  out  1  capture read data into the window buffer slot o_load_idx.
- o_load_idx  out  4  window slot index, 0..RD_PER_WIN-1.
- o_calc_start  out  1  one-cycle pulse; window is full, start the edge computation.
- i_calc_done  in  1  pulse: the computation result is ready.
- o_res_idx  out  2  result index to be written, 0..WR_PER_WIN-1.
- o_busy  out  1  high from the cycle after i_start until return to IDLE.
- o_frame_done  out  1  one-cycle pulse at the end of a frame.
- o_err  out  1  sticky timeout flag (see Configuration).
REQ-003 One clock domain; reset is asynchronous and active-low.

Function
REQ-004 States: IDLE, RADDR, RWAIT, RMEM, CALC, CWAIT, WADDR, WWAIT, WMEM, NEXT, FINISH, ERROR.
REQ-005 IDLE: when i_start=1, go to RADDR and clear rd_cnt, wr_cnt and the frame-done latch. i_start is ignored in every other state.
REQ-006 RADDR: assert o_inc_raddr for exactly one cycle, then go to RWAIT.
REQ-007 RWAIT: on i_r_ready go to RMEM. Any i_w_ready seen in this state is ignored.
REQ-008 RMEM:
- Hold o_mem_read high until i_mem_ack.
- In the ack cycle, assert o_load_en with o_load_idx=rd_cnt, and increment rd_cnt.
- If rd_cnt was RD_PER_WIN-1, go to CALC; otherwise go to RADDR.
REQ-009 CALC: pulse o_calc_start, clear rd_cnt, go to CWAIT. CWAIT: on i_calc_done go to WADDR.
REQ-010 WADDR: pulse o_inc_waddr for one cycle, go to WWAIT. WWAIT: on i_w_ready go to WMEM.
REQ-011 WMEM:
- Hold o_mem_write high with o_res_idx=wr_cnt until i_mem_ack.
- In the ack cycle, increment wr_cnt.
- If wr_cnt was WR_PER_WIN-1, go to NEXT; otherwise go to WADDR.
REQ-012 i_addr_done is latched whenever it arrives while busy. The latch is cleared only in IDLE.
REQ-013 NEXT: clear wr_cnt. If the latch is set, go to FINISH; otherwise go to RADDR.
REQ-014 FINISH: pulse o_frame_done, then go to IDLE.
REQ-015 Latencies:
- i_start to o_inc_raddr: 1 cycle.
- i_mem_ack (last read) to o_calc_start: 1 cycle.
- i_calc_done to o_inc_waddr: 1 cycle.
REQ-016 Outputs are decoded from registered state only; no combinational path from any input to any output.
REQ-017 Counters are unsigned CNT_W bits and never wrap within a window.

Reset
REQ-018 n_rst=0 forces, asynchronously:
- state=IDLE;
- rd_cnt=0, wr_cnt=0, done latch=0;
- every output to 0.
REQ-019 Reset asserted mid-frame abandons the frame. No o_frame_done is produced, and after release the block waits for a new i_start.

Configuration
REQ-020 Macro WINDOW_TIMEOUT_EN.
- Defined: an 8-bit watchdog counts cycles spent in RWAIT, RMEM, CWAIT, WWAIT or WMEM. It restarts on every state change. On reaching 255 the FSM goes to ERROR, sets o_err and drops o_busy.
- ERROR is left only by reset.
- Not defined: no watchdog and no ERROR state; o_err is tied to 0.

Verification
REQ-021 Single window: i_start; memory acks 2 cycles after each strobe; i_calc_done 5 cycles after o_calc_start -> 16 o_load_en pulses with idx 0..15, one o_calc_start, 4 writes with o_res_idx 0..3.
REQ-022 Frame end: i_addr_done pulsed during the 3rd write of the second window -> o_frame_done exactly once, after the 4th write; o_busy low the next cycle.
REQ-023 Back-to-back: i_mem_ack held high continuously -> each read beat takes 3 cycles (RADDR, RWAIT, RMEM), with i_r_ready given 1 cycle after o_inc_raddr.
REQ-024 Reset mid-frame: n_rst low during RMEM at rd_cnt=7 -> all outputs 0 immediately; a new i_start restarts with o_load_idx=0.
REQ-025 Spurious inputs: i_start and i_w_ready pulsed during RWAIT -> no state or counter change.
REQ-026 With WINDOW_TIMEOUT_EN defined: withhold i_mem_ack in RMEM -> o_err=1 after 255 cycles and stays 1 until reset. Without the macro: the block waits indefinitely and o_err stays 0.

Source files
------------

// File: rtl/window_sequencer_if.sv
// Handshake bundle between the window sequencer and its address counter,
// memory port, window buffer and edge-computation unit.
`timescale 1ns/1ps
interface window_sequencer_if;
    logic       i_start;
    logic       o_inc_raddr;
    logic       i_r_ready;
    logic       o_inc_waddr;
    logic       i_w_ready;
    logic       i_addr_done;
    logic       o_mem_read;
    logic       o_mem_write;
    logic       i_mem_ack;
    logic       o_load_en;
    logic [3:0] o_load_idx;
    logic       o_calc_start;
    logic       i_calc_done;
    logic [1:0] o_res_idx;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_err;

    modport master (
        input  i_start,
        input  i_r_ready,
        input  i_w_ready,
        input  i_addr_done,
        input  i_mem_ack,
        input  i_calc_done,
        output o_inc_raddr,
        output o_inc_waddr,
        output o_mem_read,
        output o_mem_write,
        output o_load_en,
        output o_load_idx,
        output o_calc_start,
        output o_res_idx,
        output o_busy,
        output o_frame_done,
        output o_err
    );

    modport slave (
        output i_start,
        output i_r_ready,
        output i_w_ready,
        output i_addr_done,
        output i_mem_ack,
        output i_calc_done,
        input  o_inc_raddr,
        input  o_inc_waddr,
        input  o_mem_read,
        input  o_mem_write,
        input  o_load_en,
        input  o_load_idx,
        input  o_calc_start,
        input  o_res_idx,
        input  o_busy,
        input  o_frame_done,
        input  o_err
    );
endinterface

// File: rtl/window_sequencer.sv
// Frame sequencer: reads a source window, runs the edge computation, writes results.
// Optional watchdog with ERROR state enabled by `define WINDOW_TIMEOUT_EN.
`timescale 1ns/1ps
module window_sequencer #(
    parameter int RD_PER_WIN = 16,
    parameter int WR_PER_WIN = 4,
    parameter int CNT_W      = 5
) (
    input  logic                 clk,
    input  logic                 n_rst,
    window_sequencer_if.master   bus
);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] RADDR  = 4'd1;
    localparam logic [3:0] RWAIT  = 4'd2;
    localparam logic [3:0] RMEM   = 4'd3;
    localparam logic [3:0] CALC   = 4'd4;
    localparam logic [3:0] CWAIT  = 4'd5;
    localparam logic [3:0] WADDR  = 4'd6;
    localparam logic [3:0] WWAIT  = 4'd7;
    localparam logic [3:0] WMEM   = 4'd8;
    localparam logic [3:0] NEXT   = 4'd9;
    localparam logic [3:0] FINISH = 4'd10;
`ifdef WINDOW_TIMEOUT_EN
    localparam logic [3:0] ERROR  = 4'd11;
`endif

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_PER_WIN - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PER_WIN - 1);

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
    logic             done_lat;
    logic             load_en_q;
    logic [3:0]       load_idx_q;
    logic             busy;
    logic             rd_ack;
    logic             wr_ack;
    logic             wd_hit;

    assign rd_ack = (state == RMEM) && bus.i_mem_ack;
    assign wr_ack = (state == WMEM) && bus.i_mem_ack;

`ifdef WINDOW_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       wait_st;

    assign wait_st = (state == RWAIT) || (state == RMEM) ||
                     (state == CWAIT) || (state == WWAIT) ||
                     (state == WMEM);
    assign wd_hit  = wait_st && (wd_cnt == 8'hFF);
    assign busy    = (state != IDLE) && (state != ERROR);

    // Count only while parked in a wait state; any transition restarts it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt <= 8'd0;
        end else if (!wait_st || (state_nxt != state)) begin
            wd_cnt <= 8'd0;
        end else if (wd_cnt != 8'hFF) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    assign wd_hit = 1'b0;
    assign busy   = (state != IDLE);
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.i_start) state_nxt = RADDR;
            RADDR:   state_nxt = RWAIT;
            RWAIT:   if (bus.i_r_ready) state_nxt = RMEM;
            RMEM:    if (bus.i_mem_ack)
                         state_nxt = (rd_cnt == RD_LAST) ? CALC : RADDR;
            CALC:    state_nxt = CWAIT;
            CWAIT:   if (bus.i_calc_done) state_nxt = WADDR;
            WADDR:   state_nxt = WWAIT;
            WWAIT:   if (bus.i_w_ready) state_nxt = WMEM;
            WMEM:    if (bus.i_mem_ack)
                         state_nxt = (wr_cnt == WR_LAST) ? NEXT : WADDR;
            NEXT:    state_nxt = done_lat ? FINISH : RADDR;
            FINISH:  state_nxt = IDLE;
`ifdef WINDOW_TIMEOUT_EN
            ERROR:   state_nxt = ERROR;
`endif
            default: state_nxt = IDLE;
        endcase
        if (wd_hit) begin
`ifdef WINDOW_TIMEOUT_EN
            state_nxt = ERROR;
`endif
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if ((state == IDLE) && bus.i_start) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end
            if (state == CALC) rd_cnt <= '0;
            if (state == NEXT) wr_cnt <= '0;
            if (rd_ack && !wd_hit) rd_cnt <= rd_cnt + 1'b1;
            if (wr_ack && !wd_hit) wr_cnt <= wr_cnt + 1'b1;
        end
    end

    // Frame end may be signalled any time during the frame; acted on at NEXT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            done_lat <= 1'b0;
        end else if (state == IDLE) begin
            done_lat <= 1'b0;
        end else if (busy && bus.i_addr_done) begin
            done_lat <= 1'b1;
        end
    end

    // Load strobe is registered so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            load_en_q  <= 1'b0;
            load_idx_q <= 4'd0;
        end else begin
            load_en_q <= rd_ack && !wd_hit;
            if (rd_ack) load_idx_q <= rd_cnt[3:0];
        end
    end

    assign bus.o_inc_raddr  = (state == RADDR);
    assign bus.o_inc_waddr  = (state == WADDR);
    assign bus.o_mem_read   = (state == RMEM);
    assign bus.o_mem_write  = (state == WMEM);
    assign bus.o_load_en    = load_en_q;
    assign bus.o_load_idx   = load_idx_q;
    assign bus.o_calc_start = (state == CALC);
    assign bus.o_res_idx    = wr_cnt[1:0];
    assign bus.o_busy       = busy;
    assign bus.o_frame_done = (state == FINISH);
`ifdef WINDOW_TIMEOUT_EN
    assign bus.o_err        = (state == ERROR);
`else
    assign bus.o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_window_sequencer.sv
// Scoreboard bench for window_sequencer: reactive environment model,
// frame-level reference sequence, decoupled negedge monitor.
`timescale 1ns/1ps
module tb_window_sequencer;

    logic clk;
    logic n_rst;

    window_sequencer_if bus();

    window_sequencer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WINDOW_TIMEOUT_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    int n_cmp;
    int n_bad;
    int exp_q[$];
    int frames_done;
    int loads_seen;
    int cyc;
    int last_load_cyc;
    int done_win;
    bit hold_ack;
    bit no_ack;
    bit spur;
    bit fixed_dly;
    bit b2b_chk;
    bit start_req;
    bit chk_idle;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int enc(int kind, int idx);
        return kind * 100 + idx;
    endfunction

    task automatic check(string nm, int act, int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic sb(string nm, int act);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got unexpected event %0d expected none", nm, act);
        end else begin
            check(nm, act, exp_q.pop_front());
        end
    endtask

    // Reference: every window is 16 loads, one calc, 4 writes; then one done.
    task automatic push_frame(int nwin);
        for (int w = 0; w < nwin; w++) begin
            for (int i = 0; i < 16; i++) exp_q.push_back(enc(1, i));
            exp_q.push_back(enc(2, 0));
            for (int j = 0; j < 4; j++) exp_q.push_back(enc(3, j));
        end
        exp_q.push_back(enc(4, 0));
    endtask

    // Environment: address counter, memory and compute unit responses.
    initial begin
        int  rr_t;
        int  wr_t;
        int  cd_t;
        int  ack_t;
        int  wa_cnt;
        bit  ack_arm;
        bit  prev_raddr;
        rr_t = 0; wr_t = 0; cd_t = 0; ack_t = 0;
        wa_cnt = 0; ack_arm = 0; prev_raddr = 0;
        bus.i_start = 0; bus.i_r_ready = 0; bus.i_w_ready = 0;
        bus.i_addr_done = 0; bus.i_mem_ack = 0; bus.i_calc_done = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_start     = 0;
            bus.i_r_ready   = 0;
            bus.i_w_ready   = 0;
            bus.i_calc_done = 0;
            bus.i_addr_done = 0;
            bus.i_mem_ack   = hold_ack;
            if (!n_rst) begin
                rr_t = 0; wr_t = 0; cd_t = 0;
                ack_arm = 0; prev_raddr = 0;
                continue;
            end
            if (start_req) begin
                bus.i_start = 1;
                start_req   = 0;
                wa_cnt      = 0;
            end
            if (rr_t > 0) begin
                rr_t--;
                if (rr_t == 0) bus.i_r_ready = 1;
            end
            if (spur && prev_raddr) begin
                bus.i_start   = 1;
                bus.i_w_ready = 1;
            end
            prev_raddr = bus.o_inc_raddr;
            if (bus.o_inc_raddr)
                rr_t = (fixed_dly || hold_ack) ? 1 :
                       (spur ? 3 : 1 + int'($urandom_range(0, 2)));
            if (wr_t > 0) begin
                wr_t--;
                if (wr_t == 0) bus.i_w_ready = 1;
            end
            if (bus.o_inc_waddr) begin
                wr_t = (fixed_dly || hold_ack) ? 1 : 1 + int'($urandom_range(0, 2));
                if (wa_cnt == done_win * 4 + 2) bus.i_addr_done = 1;
                wa_cnt++;
            end
            if (cd_t > 0) begin
                cd_t--;
                if (cd_t == 0) bus.i_calc_done = 1;
            end
            if (bus.o_calc_start)
                cd_t = fixed_dly ? 5 : 1 + int'($urandom_range(0, 6));
            if (!hold_ack && !no_ack) begin
                if ((bus.o_mem_read || bus.o_mem_write) && !ack_arm) begin
                    ack_arm = 1;
                    ack_t   = fixed_dly ? 2 : int'($urandom_range(0, 3));
                end
                if (ack_arm) begin
                    if (ack_t == 0) begin
                        bus.i_mem_ack = 1;
                        ack_arm       = 0;
                    end else begin
                        ack_t--;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                chk_idle = 0;
                continue;
            end
            if (chk_idle) begin
                check("busy_after_done", int'(bus.o_busy), 0);
                chk_idle = 0;
            end
            if (bus.o_load_en) begin
                sb("load", enc(1, int'(bus.o_load_idx)));
                if (b2b_chk && bus.o_load_idx != 4'd0)
                    check("beat_period", cyc - last_load_cyc, 3);
                last_load_cyc = cyc;
                loads_seen++;
            end
            if (bus.o_calc_start) sb("calc", enc(2, 0));
            if (bus.o_mem_write && bus.i_mem_ack)
                sb("write", enc(3, int'(bus.o_res_idx)));
            if (bus.o_frame_done) begin
                sb("frame_done", enc(4, 0));
                frames_done++;
                chk_idle = 1;
            end
        end
    end

    task automatic run_frame(int nwin);
        int f0;
        int t;
        done_win = nwin - 1;
        push_frame(nwin);
        f0 = frames_done;
        @(posedge clk);
        start_req = 1;
        t = 0;
        while (frames_done == f0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (frames_done == f0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got no frame_done expected one");
        end
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic int all_outs();
        return int'({bus.o_inc_raddr, bus.o_inc_waddr, bus.o_mem_read,
                     bus.o_mem_write, bus.o_load_en, bus.o_load_idx,
                     bus.o_calc_start, bus.o_res_idx, bus.o_busy,
                     bus.o_frame_done, bus.o_err});
    endfunction

    initial begin
        int t;
        n_cmp = 0; n_bad = 0; frames_done = 0; loads_seen = 0;
        cyc = 0; last_load_cyc = 0; done_win = 0;
        hold_ack = 0; no_ack = 0; spur = 0; fixed_dly = 0;
        b2b_chk = 0; start_req = 0; chk_idle = 0;
        n_rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", all_outs(), 0);
        check("rst_busy", int'(bus.o_busy), 0);
        check("rst_err", int'(bus.o_err), 0);
        n_rst = 1;
        repeat (2) @(negedge clk);

        fixed_dly = 1;
        run_frame(1);
        fixed_dly = 0;
        run_frame(2);

        hold_ack = 1; b2b_chk = 1;
        run_frame(1);
        hold_ack = 0; b2b_chk = 0;

        spur = 1;
        run_frame(1);
        spur = 0;

        for (int i = 0; i < 4; i++) run_frame(1 + int'($urandom_range(0, 2)));

        // Abandon a frame mid-read and restart it.
        push_frame(1);
        loads_seen = 0;
        @(posedge clk);
        start_req = 1;
        t = 0;
        while (!(loads_seen == 7 && bus.o_mem_read) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("reach_rd7", loads_seen, 7);
        n_rst = 0;
        #1;
        check("rst_mid_outputs", all_outs(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        n_rst = 1;
        repeat (5) @(negedge clk);
        check("idle_after_rst", int'(bus.o_busy), 0);
        run_frame(1);

        // Withheld memory ack.
        no_ack = 1;
        @(posedge clk);
        start_req = 1;
        t = 0;
        while (!bus.o_mem_read && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reach_rmem", int'(bus.o_mem_read), 1);
        repeat (300) @(negedge clk);
        check("err_flag", int'(bus.o_err), EXP_ERR);
        check("busy_in_wait", int'(bus.o_busy), 1 - EXP_ERR);
        check("read_held", int'(bus.o_mem_read), 1 - EXP_ERR);
        repeat (20) @(negedge clk);
        check("err_sticky", int'(bus.o_err), EXP_ERR);
        n_rst = 0;
        #1;
        check("err_cleared", int'(bus.o_err), 0);
        no_ack = 0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        n_rst = 1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
